// File: rtl/synapse_weight_arbiter.sv
// synapse_weight_arbiter: shares the single-port weight RAM between the
// host config port (priority, with a starvation guard) and round-robin cores.
module synapse_weight_arbiter #(
    parameter int NUM_SYNAPSES = 220,
    parameter int ADDR_W       = 8,
    parameter int NUM_REQ      = 4,
    parameter int HOST_BURST   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        core_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] core_req_addr,
    output logic [NUM_REQ-1:0]        core_req_ready,
    output logic [NUM_REQ-1:0]        core_rsp_valid,
    output logic [15:0]               core_rsp_data,
    output logic                      core_rsp_err,
    input  logic                      host_valid,
    input  logic                      host_we,
    input  logic [ADDR_W-1:0]         host_addr,
    input  logic [15:0]               host_wdata,
    output logic                      host_ready,
    output logic                      host_rsp_valid,
    output logic [15:0]               host_rsp_data,
    output logic                      host_rsp_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [15:0]               mem_wdata,
    input  logic [15:0]               mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int STK_W = $clog2(HOST_BURST + 1);
    localparam logic [ADDR_W:0]  NSYN  = (ADDR_W + 1)'(NUM_SYNAPSES);
    localparam logic [STK_W-1:0] BURST = STK_W'(HOST_BURST);

    logic               any_core, guard_trip, host_gnt, core_gnt;
    logic               hi_found, acc_valid, acc_oor;
    logic [IDX_W-1:0]   hi_sel, lo_sel, core_sel;
    logic [ADDR_W-1:0]  core_addr, acc_addr;
    logic [15:0]        rd_data;

    logic [STK_W-1:0]   host_streak_d, host_streak_q;
    logic [IDX_W-1:0]   rr_ptr_d, rr_ptr_q;

    logic               t1_valid_d, t1_valid_q;
    logic               t1_host_d, t1_host_q;
    logic [IDX_W-1:0]   t1_id_d, t1_id_q;
    logic               t1_rd_d, t1_rd_q;
    logic               t1_err_d, t1_err_q;

    logic [NUM_REQ-1:0] core_rsp_valid_d, core_rsp_valid_q;
    logic [15:0]        core_rsp_data_d, core_rsp_data_q;
    logic               core_rsp_err_d, core_rsp_err_q;
    logic               host_rsp_valid_d, host_rsp_valid_q;
    logic [15:0]        host_rsp_data_d, host_rsp_data_q;
    logic               host_rsp_err_d, host_rsp_err_q;

    // Pick the single winner: host unless the guard trips, else next core after rr_ptr.
    always_comb begin
        any_core   = |core_req_valid;
        guard_trip = any_core && (host_streak_q == BURST);
        host_gnt   = !rst && host_valid && !guard_trip;
        core_gnt   = !rst && !host_gnt && any_core;
        hi_found   = 1'b0;
        hi_sel     = '0;
        lo_sel     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (core_req_valid[i]) begin
                if (IDX_W'(i) > rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_sel   = IDX_W'(i);
                end else begin
                    lo_sel = IDX_W'(i);
                end
            end
        end
        core_sel = hi_found ? hi_sel : lo_sel;
        core_req_ready = '0;
        if (core_gnt) core_req_ready[core_sel] = 1'b1;
        host_ready = host_gnt;
    end

    // Steer the granted request onto the RAM port; out-of-range never touches RAM.
    always_comb begin
        core_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == core_sel) core_addr = core_req_addr[i*ADDR_W +: ADDR_W];
        end
        acc_addr  = host_gnt ? host_addr : core_addr;
        acc_valid = host_gnt || core_gnt;
        acc_oor   = {1'b0, acc_addr} >= NSYN;
        mem_en    = acc_valid && !acc_oor;
        mem_we    = host_gnt && host_we && !acc_oor;
        mem_addr  = mem_en ? acc_addr : '0;
        mem_wdata = mem_we ? host_wdata : '0;
    end

    // Arbitration state and first tag stage for the access issued this cycle.
    always_comb begin
        host_streak_d = host_streak_q;
        if (core_gnt || !any_core) host_streak_d = '0;
        else if (host_gnt)         host_streak_d = host_streak_q + 1'b1;
        rr_ptr_d   = core_gnt ? core_sel : rr_ptr_q;
        t1_valid_d = acc_valid;
        t1_host_d  = host_gnt;
        t1_id_d    = core_sel;
        t1_rd_d    = core_gnt || !host_we;
        t1_err_d   = acc_oor;
    end

    // Response stage: capture RAM data and strobe the owning requester.
    always_comb begin
        rd_data          = (t1_rd_q && !t1_err_q) ? mem_rdata : '0;
        core_rsp_valid_d = '0;
        core_rsp_data_d  = core_rsp_data_q;
        core_rsp_err_d   = core_rsp_err_q;
        host_rsp_valid_d = 1'b0;
        host_rsp_data_d  = host_rsp_data_q;
        host_rsp_err_d   = host_rsp_err_q;
        if (t1_valid_q) begin
            if (t1_host_q) begin
                host_rsp_valid_d = 1'b1;
                host_rsp_data_d  = rd_data;
                host_rsp_err_d   = t1_err_q;
            end else begin
                core_rsp_valid_d[t1_id_q] = 1'b1;
                core_rsp_data_d           = rd_data;
                core_rsp_err_d            = t1_err_q;
            end
        end
    end

    // Registers; reset drops any in-flight tags and response strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            host_streak_q    <= '0;
            rr_ptr_q         <= IDX_W'(NUM_REQ - 1);
            t1_valid_q       <= 1'b0;
            t1_host_q        <= 1'b0;
            t1_id_q          <= '0;
            t1_rd_q          <= 1'b0;
            t1_err_q         <= 1'b0;
            core_rsp_valid_q <= '0;
            core_rsp_data_q  <= '0;
            core_rsp_err_q   <= 1'b0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_data_q  <= '0;
            host_rsp_err_q   <= 1'b0;
        end else begin
            host_streak_q    <= host_streak_d;
            rr_ptr_q         <= rr_ptr_d;
            t1_valid_q       <= t1_valid_d;
            t1_host_q        <= t1_host_d;
            t1_id_q          <= t1_id_d;
            t1_rd_q          <= t1_rd_d;
            t1_err_q         <= t1_err_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            core_rsp_data_q  <= core_rsp_data_d;
            core_rsp_err_q   <= core_rsp_err_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            host_rsp_data_q  <= host_rsp_data_d;
            host_rsp_err_q   <= host_rsp_err_d;
        end
    end

    assign core_rsp_valid = core_rsp_valid_q;
    assign core_rsp_data  = core_rsp_data_q;
    assign core_rsp_err   = core_rsp_err_q;
    assign host_rsp_valid = host_rsp_valid_q;
    assign host_rsp_data  = host_rsp_data_q;
    assign host_rsp_err   = host_rsp_err_q;

endmodule

// File: tb/tb_synapse_weight_arbiter.sv
// tb_synapse_weight_arbiter: directed and random traffic against a
// transaction-level model of arbitration, RAM contents and response timing.
module tb_synapse_weight_arbiter;

    localparam int NS = 220;
    localparam int AW = 8;
    localparam int NR = 4;
    localparam int HB = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    core_req_valid;
    logic [NR*AW-1:0] core_req_addr;
    logic [NR-1:0]    core_req_ready;
    logic [NR-1:0]    core_rsp_valid;
    logic [15:0]      core_rsp_data;
    logic             core_rsp_err;
    logic             host_valid;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [15:0]      host_wdata;
    logic             host_ready;
    logic             host_rsp_valid;
    logic [15:0]      host_rsp_data;
    logic             host_rsp_err;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [15:0]      mem_wdata;
    logic [15:0]      mem_rdata;

    always #5 clk = ~clk;

    synapse_weight_arbiter #(
        .NUM_SYNAPSES(NS), .ADDR_W(AW), .NUM_REQ(NR), .HOST_BURST(HB)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
        .core_req_ready(core_req_ready), .core_rsp_valid(core_rsp_valid),
        .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err),
        .host_valid(host_valid), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rsp_valid(host_rsp_valid),
        .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Weight RAM with 1-cycle read latency
    logic [15:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        int          due;
        bit          host;
        int          id;
        logic [15:0] data;
        bit          err;
    } rsp_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          streak = 0;
    int          rr = NR - 1;
    logic [15:0] mm [0:255];
    logic [15:0] exp_cd = '0;
    logic [15:0] exp_hd = '0;
    rsp_t        pend[$];
    bit          hold_core [NR];
    bit          hold_host = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic set_core(input int i, input logic [AW-1:0] a);
        core_req_valid[i] = 1'b1;
        core_req_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int r = $urandom_range(0, 9);
        if (r < 2)      return AW'($urandom_range(220, 255));
        else if (r < 6) return AW'($urandom_range(210, 219));
        else            return AW'($urandom_range(0, 219));
    endfunction

    // One clock: check comb grant/RAM outputs and registered responses, advance model.
    task automatic step();
        int            ec;
        bit            eh, anyc, oor, we;
        logic [AW-1:0] a;
        logic [NR-1:0] ev, ecv;
        bit            ehv;
        rsp_t          r;
        @(negedge clk);
        anyc = (core_req_valid != '0);
        eh = 1'b0;
        ec = -1;
        if (!rst) begin
            if (host_valid && !(anyc && streak == HB)) eh = 1'b1;
            else if (anyc)
                for (int k = 1; k <= NR; k++)
                    if (ec < 0 && core_req_valid[(rr + k) % NR]) ec = (rr + k) % NR;
        end
        ev = '0;
        if (ec >= 0) ev[ec] = 1'b1;
        check_eq("host_ready", 32'(host_ready), 32'(eh));
        check_eq("core_req_ready", 32'(core_req_ready), 32'(ev));
        a = eh ? host_addr : (ec >= 0 ? core_req_addr[ec*AW +: AW] : '0);
        oor = int'(a) >= NS;
        we = eh && host_we;
        check_eq("mem_en", 32'(mem_en), 32'((eh || ec >= 0) && !oor));
        if ((eh || ec >= 0) && !oor) begin
            check_eq("mem_addr", 32'(mem_addr), 32'(a));
            check_eq("mem_we", 32'(mem_we), 32'(we));
            if (we) check_eq("mem_wdata", 32'(mem_wdata), 32'(host_wdata));
        end
        ecv = '0;
        ehv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.host) begin
                ehv = 1'b1;
                exp_hd = r.data;
                check_eq("host_rsp_err", 32'(host_rsp_err), 32'(r.err));
            end else begin
                ecv[r.id] = 1'b1;
                exp_cd = r.data;
                check_eq("core_rsp_err", 32'(core_rsp_err), 32'(r.err));
            end
        end
        check_eq("core_rsp_valid", 32'(core_rsp_valid), 32'(ecv));
        check_eq("host_rsp_valid", 32'(host_rsp_valid), 32'(ehv));
        check_eq("core_rsp_data", 32'(core_rsp_data), 32'(exp_cd));
        check_eq("host_rsp_data", 32'(host_rsp_data), 32'(exp_hd));
        if (rst) begin
            pend.delete();
            exp_cd = '0;
            exp_hd = '0;
            streak = 0;
            rr = NR - 1;
        end else begin
            if (eh || ec >= 0) begin
                r.due  = cyc + 2;
                r.host = eh;
                r.id   = ec;
                r.err  = oor;
                r.data = (oor || we) ? 16'h0 : mm[a];
                pend.push_back(r);
                if (we && !oor) mm[a] = host_wdata;
            end
            if (ec >= 0 || !anyc) streak = 0;
            else if (eh)          streak++;
            if (ec >= 0) rr = ec;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (ec >= 0 && !hold_core[ec]) core_req_valid[ec] = 1'b0;
        if (eh && !hold_host) host_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'(i * 37 + 11);
            mm[i]  = 16'(i * 37 + 11);
        end
        ram[5] = 16'h1234;
        mm[5]  = 16'h1234;
        for (int i = 0; i < NR; i++) hold_core[i] = 1'b0;
        core_req_valid = '0;
        core_req_addr  = '0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        steps(2);
        rst = 1'b0;
        check_eq("rst_core_err", 32'(core_rsp_err), 32'd0);
        check_eq("rst_host_err", 32'(host_rsp_err), 32'd0);
        step();

        // single core read
        set_core(2, 8'd5);
        steps(4);

        // host write then read of the top address
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'd219; host_wdata = 16'hBEEF;
        step();
        host_valid = 1'b1; host_we = 1'b0;
        steps(4);

        // out-of-range from both sides
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'd220;
        set_core(0, 8'd255);
        steps(5);

        // round robin with all cores held
        for (int i = 0; i < NR; i++) begin
            hold_core[i] = 1'b1;
            set_core(i, AW'(i + 10));
        end
        steps(6);
        for (int i = 0; i < NR; i++) hold_core[i] = 1'b0;
        steps(6);

        // starvation guard: host and core 1 held
        hold_host = 1'b1; hold_core[1] = 1'b1;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'd7;
        set_core(1, 8'd9);
        steps(15);
        hold_host = 1'b0; hold_core[1] = 1'b0;
        steps(5);

        // reset with a core 3 read in flight
        set_core(3, 8'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < NR; i++) set_core(i, AW'(i + 20));
        steps(8);

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++)
                if (!core_req_valid[i] && $urandom_range(0, 2) == 0) set_core(i, rnd_addr());
            if (!host_valid && $urandom_range(0, 2) == 0) begin
                host_valid = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = rnd_addr();
                host_wdata = 16'($urandom);
            end
            rst = (n % 700 == 699);
            step();
        end
        rst = 1'b0;
        core_req_valid = '0;
        host_valid = 1'b0;
        steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/synapse_weight_arbiter.md
# synapse_weight_arbiter

Arbitrates the single-port synaptic weight RAM between a host configuration port and NUM_REQ neuron-core weight-fetch requesters. Host accesses take priority, bounded by a starvation guard, and cores share the remaining slots round-robin. The block sits between the AXI-Lite host bridge / neuron cores and the weight RAM, which has a 1-cycle read latency. It issues at most one RAM access per cycle and returns responses with a fixed latency.

## Interface
Parameters:
- NUM_SYNAPSES, 220, number of 16-bit weight words; valid addresses are 0..NUM_SYNAPSES-1
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= NUM_SYNAPSES
- NUM_REQ, 4, number of core requesters (2..16)
- HOST_BURST, 4, maximum consecutive host grants while any core is waiting (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- core_req_valid  in  NUM_REQ  per-core read request
- core_req_addr  in  NUM_REQ*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
- core_req_ready  out  NUM_REQ  one-hot grant, combinational
- core_rsp_valid  out  NUM_REQ  one-hot response strobe
- core_rsp_data  out  16  read data, shared by all cores
- core_rsp_err  out  1  out-of-range error, qualified by core_rsp_valid
- host_valid  in  1  host request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  16  host write data
- host_ready  out  1  host grant, combinational
- host_rsp_valid  out  1  host response strobe
- host_rsp_data  out  16  host read data; 0 for writes and errors
- host_rsp_err  out  1  out-of-range error
- mem_en, mem_we  out  1 each  RAM enable and write enable, combinational
- mem_addr  out  ADDR_W  RAM address, combinational
- mem_wdata  out  16  RAM write data, combinational
- mem_rdata  in  16  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- One grant at most per cycle. A request is accepted in cycle t when valid & ready are both high. Requesters hold valid and addr stable until accepted.
- Grant selection:
  - If host_valid is high and the starvation guard is not tripped, the host wins.
  - Otherwise, the first valid core wins, searching from rr_ptr+1 modulo NUM_REQ.
- Starvation guard:
  - host_streak counter (width covers HOST_BURST) increments on each host grant made while any core_req_valid is high.
  - It clears on any core grant, and in any cycle where no core is valid.
  - The guard is tripped when host_streak == HOST_BURST and any core is valid. The host is then denied for that cycle.
- rr_ptr updates to the granted core index on core grants only. rr_ptr holds on host grants and idle cycles.
- In-range accepted access: mem_en=1 and mem_addr=addr in cycle t. mem_we and mem_wdata are driven only for host writes; mem_we=0 for all core accesses.
- Out-of-range access (addr >= NUM_SYNAPSES): mem_en=0, the request is still accepted, and its response carries err=1 and data=0.
- Host write response: err=0 and data=0, returned with the same latency as a read.
- A 2-stage tag pipeline carries the requester id, read flag, and err flag to the response stage.

## Timing
- Response latency is fixed at 2 cycles: acceptance in cycle t gives rsp_valid high in cycle t+2 for exactly one cycle.
- mem_rdata is sampled at the end of cycle t+1 and registered into rsp_data.
- Responses have no backpressure. Throughput is one access per cycle, sustained back-to-back.
- Reset values:
  - core_rsp_valid=0, core_rsp_data=0, core_rsp_err=0
  - host_rsp_valid=0, host_rsp_data=0, host_rsp_err=0
  - host_streak=0, rr_ptr=NUM_REQ-1, so core 0 has first priority
  - all tag-pipeline stages invalid
- While rst is high, all ready outputs are 0 and mem_en=0.
- Reset mid-operation: in-flight responses are discarded with no strobe after reset, and any write accepted before reset has already completed.
- Simultaneous host and core requests: handled by the grant rule above. No requester is ever granted twice in one cycle.
- rsp_data holds its last value when no response is being strobed.

## Test plan
- Single core read:
  - Preload weight[5]=0x1234; core 2 reads addr 5 in cycle t.
  - Expect core_req_ready=0b0100 in t, mem_en=1 with mem_addr=5, then core_rsp_valid=0b0100 in t+2 with core_rsp_data=0x1234 and err=0.
- Host write then read:
  - Host writes 0xBEEF to addr 219, then reads addr 219 on the next cycle.
  - Expect two host_rsp_valid pulses, at t+2 (data 0, err 0) and t+3 (data 0xBEEF).
- Out-of-range access:
  - Host reads addr 220 and core 0 reads addr 255.
  - Expect mem_en=0 on both accepts; both responses have err=1 and data=0.
- Round-robin fairness:
  - All 4 cores hold valid continuously with the host idle.
  - Expect grant order 0,1,2,3,0,1 over 6 consecutive cycles and responses back-to-back.
- Starvation guard (HOST_BURST=4):
  - Host and core 1 hold valid continuously.
  - Expect grants H,H,H,H,C1 repeating; host_streak returns to 0 after each C1 grant.
- Reset mid-flight:
  - Accept a core 3 read in cycle t, then assert rst in t+1.
  - Expect no core_rsp_valid in t+2; after reset, rr_ptr=3, so core 0 wins the first contested cycle.
